lvt_write_batcher: RTL and testbench

LVT_WRITE_BATCHER -- requirements
Module: lvt_write_batcher

---
 rtl/lvt_pkg.sv | 18 +
 rtl/lvt_addr_cam.sv | 32 +++
 rtl/lvt_write_batcher.sv | 170 +++++++++++++++++
 tb/tb_lvt_write_batcher.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvt_pkg.sv
// Shared constants and the COLLECT/ISSUE state encoding for the LVT write
// batcher and its address CAM.
package lvt_pkg;
    localparam int NPORTS  = 8;
    localparam int DATA_W  = 32;
    localparam int IDX_W   = 3;
    localparam int FILL_W  = 4;
    localparam int TIMER_W = 8;

    function automatic int addr_width(input int blocksize);
        return blocksize + 1;
    endfunction

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_ISSUE   = 1'b1
    } state_t;
endpackage

// File: rtl/lvt_addr_cam.sv
// Eight-entry address match over the occupied batch slots; returns whether the
// search address is already present and which slot holds it.
module lvt_addr_cam
    import lvt_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic [AW-1:0]    entry_addr [NPORTS],
    input  logic [NPORTS-1:0] entry_valid,
    input  logic [AW-1:0]    search_addr,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx
);
    logic [NPORTS-1:0] match;

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_match
            assign match[gi] = entry_valid[gi] && (entry_addr[gi] == search_addr);
        end
    endgenerate

    assign hit = |match;

    // The batch never holds duplicates, so at most one bit is set and the
    // scan direction does not matter.
    always_comb begin
        hit_idx = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (match[k]) hit_idx = IDX_W'(k);
        end
    end
endmodule

// File: rtl/lvt_write_batcher.sv
// Collects up to eight distinct-address writes and issues them together to the
// eight write ports of an LVT multi-port RAM, coalescing repeated addresses.
module lvt_write_batcher
    import lvt_pkg::*;
#(
    parameter int BLOCKSIZE = 11,
    parameter int TIMEOUT   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BLOCKSIZE:0]         in_addr,
    input  logic [DATA_W-1:0]          in_din,
    input  logic                       flush,
    output logic [BLOCKSIZE:0]         w_addr_1,
    output logic [BLOCKSIZE:0]         w_addr_2,
    output logic [BLOCKSIZE:0]         w_addr_3,
    output logic [BLOCKSIZE:0]         w_addr_4,
    output logic [BLOCKSIZE:0]         w_addr_5,
    output logic [BLOCKSIZE:0]         w_addr_6,
    output logic [BLOCKSIZE:0]         w_addr_7,
    output logic [BLOCKSIZE:0]         w_addr_8,
    output logic [DATA_W-1:0]          w_din_1,
    output logic [DATA_W-1:0]          w_din_2,
    output logic [DATA_W-1:0]          w_din_3,
    output logic [DATA_W-1:0]          w_din_4,
    output logic [DATA_W-1:0]          w_din_5,
    output logic [DATA_W-1:0]          w_din_6,
    output logic [DATA_W-1:0]          w_din_7,
    output logic [DATA_W-1:0]          w_din_8,
    output logic                       w_enb_1,
    output logic                       w_enb_2,
    output logic                       w_enb_3,
    output logic                       w_enb_4,
    output logic                       w_enb_5,
    output logic                       w_enb_6,
    output logic                       w_enb_7,
    output logic                       w_enb_8,
    output logic [FILL_W-1:0]          fill,
    output logic                       busy
);
    localparam int AW = addr_width(BLOCKSIZE);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(NPORTS);

    state_t               state_reg;
    logic [FILL_W-1:0]    fill_reg, fill_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic [AW-1:0]        slot_addr_reg [NPORTS];
    logic [AW-1:0]        slot_addr_next [NPORTS];
    logic [DATA_W-1:0]    slot_din_reg [NPORTS];
    logic [DATA_W-1:0]    slot_din_next [NPORTS];
    logic [NPORTS-1:0]    slot_valid, issue_valid;
    logic [AW-1:0]        w_addr_reg [NPORTS];
    logic [DATA_W-1:0]    w_din_reg [NPORTS];
    logic [NPORTS-1:0]    w_enb_reg;
    logic                 accept, hit, trigger;
    logic [IDX_W-1:0]     hit_idx;

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_valid
            assign slot_valid[gi]  = fill_reg  > FILL_W'(gi);
            assign issue_valid[gi] = fill_next > FILL_W'(gi);
        end
    endgenerate

    lvt_addr_cam #(.AW(AW)) u_cam (
        .entry_addr  (slot_addr_reg),
        .entry_valid (slot_valid),
        .search_addr (in_addr),
        .hit         (hit),
        .hit_idx     (hit_idx)
    );

    assign in_ready = (state_reg == ST_COLLECT);
    assign accept   = in_valid && in_ready;

    always_comb begin
        slot_addr_next = slot_addr_reg;
        slot_din_next  = slot_din_reg;
        fill_next      = fill_reg;
        if (accept) begin
            if (hit) begin
                slot_din_next[hit_idx] = in_din;
            end else begin
                // fill_reg never exceeds 7 while collecting; a full batch issues at once.
                slot_addr_next[fill_reg[IDX_W-1:0]] = in_addr;
                slot_din_next[fill_reg[IDX_W-1:0]]  = in_din;
                fill_next = fill_reg + 1'b1;
            end
        end
        timer_next = (fill_next != '0) ? timer_reg + 1'b1 : '0;
        trigger = (state_reg == ST_COLLECT) && (fill_next != '0) &&
                  ((fill_next == FILL_FULL) || (timer_reg == TIMER_LAST) || flush);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_COLLECT;
            fill_reg  <= '0;
            timer_reg <= '0;
            w_enb_reg <= '0;
            busy      <= 1'b0;
            for (int k = 0; k < NPORTS; k++) begin
                slot_addr_reg[k] <= '0;
                slot_din_reg[k]  <= '0;
                w_addr_reg[k]    <= '0;
                w_din_reg[k]     <= '0;
            end
        end else begin
            case (state_reg)
                ST_COLLECT: begin
                    if (trigger) begin
                        for (int k = 0; k < NPORTS; k++) begin
                            w_enb_reg[k]  <= issue_valid[k];
                            w_addr_reg[k] <= issue_valid[k] ? slot_addr_next[k] : '0;
                            w_din_reg[k]  <= issue_valid[k] ? slot_din_next[k]  : '0;
                        end
                        fill_reg  <= '0;
                        timer_reg <= '0;
                        busy      <= 1'b1;
                        state_reg <= ST_ISSUE;
                    end else begin
                        slot_addr_reg <= slot_addr_next;
                        slot_din_reg  <= slot_din_next;
                        fill_reg      <= fill_next;
                        timer_reg     <= timer_next;
                    end
                end
                default: begin
                    for (int k = 0; k < NPORTS; k++) begin
                        w_addr_reg[k] <= '0;
                        w_din_reg[k]  <= '0;
                    end
                    w_enb_reg <= '0;
                    busy      <= 1'b0;
                    state_reg <= ST_COLLECT;
                end
            endcase
        end
    end

    assign fill = fill_reg;

    assign w_addr_1 = w_addr_reg[0];
    assign w_addr_2 = w_addr_reg[1];
    assign w_addr_3 = w_addr_reg[2];
    assign w_addr_4 = w_addr_reg[3];
    assign w_addr_5 = w_addr_reg[4];
    assign w_addr_6 = w_addr_reg[5];
    assign w_addr_7 = w_addr_reg[6];
    assign w_addr_8 = w_addr_reg[7];
    assign w_din_1  = w_din_reg[0];
    assign w_din_2  = w_din_reg[1];
    assign w_din_3  = w_din_reg[2];
    assign w_din_4  = w_din_reg[3];
    assign w_din_5  = w_din_reg[4];
    assign w_din_6  = w_din_reg[5];
    assign w_din_7  = w_din_reg[6];
    assign w_din_8  = w_din_reg[7];
    assign w_enb_1  = w_enb_reg[0];
    assign w_enb_2  = w_enb_reg[1];
    assign w_enb_3  = w_enb_reg[2];
    assign w_enb_4  = w_enb_reg[3];
    assign w_enb_5  = w_enb_reg[4];
    assign w_enb_6  = w_enb_reg[5];
    assign w_enb_7  = w_enb_reg[6];
    assign w_enb_8  = w_enb_reg[7];
endmodule

// File: tb/tb_lvt_write_batcher.sv
// Scoreboard bench for lvt_write_batcher: expected batches are queued as
// requests are driven and popped when the write ports fire.
module tb_lvt_write_batcher;
    typedef struct packed {
        logic [7:0]        enb;
        logic [7:0][11:0]  addr;
        logic [7:0][31:0]  din;
    } batch_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [11:0] in_addr = '0;
    logic [31:0] in_din = '0;
    wire         in_ready, busy;
    wire  [3:0]  fill;
    wire  [7:0]  w_enb;
    wire  [11:0] w_addr [8];
    wire  [31:0] w_din [8];

    int     checks = 0;
    int     fails  = 0;
    batch_t exp_q[$];

    always #5 clk = ~clk;

    lvt_write_batcher #(.BLOCKSIZE(11), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_din(in_din), .flush(flush),
        .w_addr_1(w_addr[0]), .w_addr_2(w_addr[1]), .w_addr_3(w_addr[2]), .w_addr_4(w_addr[3]),
        .w_addr_5(w_addr[4]), .w_addr_6(w_addr[5]), .w_addr_7(w_addr[6]), .w_addr_8(w_addr[7]),
        .w_din_1(w_din[0]), .w_din_2(w_din[1]), .w_din_3(w_din[2]), .w_din_4(w_din[3]),
        .w_din_5(w_din[4]), .w_din_6(w_din[5]), .w_din_7(w_din[6]), .w_din_8(w_din[7]),
        .w_enb_1(w_enb[0]), .w_enb_2(w_enb[1]), .w_enb_3(w_enb[2]), .w_enb_4(w_enb[3]),
        .w_enb_5(w_enb[4]), .w_enb_6(w_enb[5]), .w_enb_7(w_enb[6]), .w_enb_8(w_enb[7]),
        .fill(fill), .busy(busy)
    );

    function automatic batch_t observe();
        batch_t b;
        b.enb = w_enb;
        for (int k = 0; k < 8; k++) begin
            b.addr[k] = w_addr[k];
            b.din[k]  = w_din[k];
        end
        return b;
    endfunction

    function automatic batch_t make_batch(int n, logic [11:0] a0, logic [31:0] d0);
        batch_t b = '0;
        for (int k = 0; k < n; k++) begin
            b.enb[k]  = 1'b1;
            b.addr[k] = a0 + 12'(k);
            b.din[k]  = d0 + 32'(k);
        end
        return b;
    endfunction

    // One accepted request, driven at a falling edge; returns at the next one.
    task automatic send(input logic [11:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_din   = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        checks++;
        if ({busy, fill, w_enb} !== 13'd0 || w_addr[0] !== 12'd0 || w_din[7] !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b fill=%0d enb=%b addr1=%h din8=%h, required all zero",
                     busy, fill, w_enb, w_addr[0], w_din[7]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || fill !== 4'd0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b busy=%b fill=%0d, required 1 0 0", in_ready, busy, fill);
        end
        $display("reset: released, in_ready=%b fill=%0d", in_ready, fill);
    endtask

    task automatic test_full_batch();
        batch_t obs, exp;
        exp_q.push_back(make_batch(8, 12'h010, 32'hA0));
        for (int i = 0; i < 7; i++) begin
            send(12'h010 + 12'(i), 32'hA0 + 32'(i));
            checks++;
            if (fill !== 4'(i + 1) || w_enb !== 8'h00) begin
                fails++;
                $display("FAIL full_fill_%0d: fill=%0d enb=%b, required %0d 00000000", i, fill, w_enb, i + 1);
            end
        end
        send(12'h017, 32'hA7);
        obs = observe();
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL full_batch: nothing queued, got %h", obs);
        end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
                fails++;
                $display("FAIL full_batch: got %h required %h", obs, exp);
            end
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || fill !== 4'd0) begin
            fails++;
            $display("FAIL full_issue_state: busy=%b in_ready=%b fill=%0d, required 1 0 0", busy, in_ready, fill);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || w_enb !== 8'h00 || w_addr[3] !== 12'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_one_cycle: busy=%b enb=%b addr4=%h in_ready=%b, required 0 0 0 1",
                     busy, w_enb, w_addr[3], in_ready);
        end
        $display("full_batch: 8 writes issued, enb=%b", obs.enb);
    endtask

    task automatic test_coalesce_timeout();
        batch_t obs, exp;
        int n;
        exp = '0;
        exp.enb[0] = 1'b1; exp.addr[0] = 12'h055; exp.din[0] = 32'h2;
        exp_q.push_back(exp);
        send(12'h055, 32'h1);
        send(12'h055, 32'h2);
        checks++;
        if (fill !== 4'd1) begin
            fails++;
            $display("FAIL coalesce_fill: fill=%0d, required 1", fill);
        end
        n = 2;
        while (w_enb === 8'h00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 16) begin
            fails++;
            $display("FAIL timeout_latency: issued %0d cycles after first accept, required 16", n);
        end
        obs = observe();
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL coalesce_batch: nothing queued, got %h", obs);
        end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
                fails++;
                $display("FAIL coalesce_batch: got %h required %h", obs, exp);
            end
        end
        @(negedge clk);
        $display("coalesce_timeout: issued after %0d cycles, din1=%h", n, obs.din[0]);
    endtask

    task automatic test_flush();
        batch_t obs, exp;
        int seen;
        exp_q.push_back(make_batch(3, 12'h100, 32'h300));
        for (int i = 0; i < 3; i++) send(12'h100 + 12'(i), 32'h300 + 32'(i));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        obs = observe();
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL flush_batch: nothing queued, got %h", obs);
        end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
                fails++;
                $display("FAIL flush_batch: got %h required %h", obs, exp);
            end
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (w_enb !== 8'h00 || busy !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL flush_empty: %0d cycles with enb/busy active, required 0", seen);
        end
        // Flush together with the very first accept still issues that write.
        exp_q.push_back(make_batch(1, 12'h3A0, 32'h77));
        flush = 1'b1;
        send(12'h3A0, 32'h77);
        flush = 1'b0;
        obs = observe();
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL flush_with_accept: nothing queued, got %h", obs);
        end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
                fails++;
                $display("FAIL flush_with_accept: got %h required %h", obs, exp);
            end
        end
        @(negedge clk);
        $display("flush: 3-slot batch enb=%b, empty flush ignored", w_enb);
    endtask

    task automatic test_back_to_back();
        batch_t obs, exp;
        exp_q.push_back(make_batch(8, 12'h200, 32'h500));
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_addr = 12'h200 + 12'(i);
            in_din  = 32'h500 + 32'(i);
            checks++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready_%0d: in_ready=%b, required 1", i, in_ready);
            end
            @(negedge clk);
        end
        in_addr = 12'h208;
        in_din  = 32'h508;
        obs = observe();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_stall: in_ready=%b busy=%b, required 0 1", in_ready, busy);
        end
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL b2b_batch: nothing queued, got %h", obs);
        end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
                fails++;
                $display("FAIL b2b_batch: got %h required %h", obs, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || fill !== 4'd0) begin
            fails++;
            $display("FAIL b2b_back_to_collect: in_ready=%b fill=%0d, required 1 0", in_ready, fill);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (fill !== 4'd1) begin
            fails++;
            $display("FAIL b2b_ninth_accept: fill=%0d, required 1", fill);
        end
        exp_q.push_back(make_batch(1, 12'h208, 32'h508));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        obs = observe();
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL b2b_slot0: nothing queued, got %h", obs);
        end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
                fails++;
                $display("FAIL b2b_slot0: got %h required %h", obs, exp);
            end
        end
        @(negedge clk);
        $display("back_to_back: ninth request landed in slot 0 addr=%h", obs.addr[0]);
    endtask

    task automatic test_reset_during_issue();
        batch_t obs, exp;
        int seen;
        exp_q.push_back(make_batch(8, 12'h400, 32'hC0));
        for (int i = 0; i < 8; i++) send(12'h400 + 12'(i), 32'hC0 + 32'(i));
        obs = observe();
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rst_issue_batch: nothing queued, got %h", obs);
        end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
                fails++;
                $display("FAIL rst_issue_batch: got %h required %h", obs, exp);
            end
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (w_enb !== 8'h00 || busy !== 1'b0 || fill !== 4'd0 || w_din[0] !== 32'd0) begin
            fails++;
            $display("FAIL rst_async_drop: enb=%b busy=%b fill=%0d din1=%h, required all zero",
                     w_enb, busy, fill, w_din[0]);
        end
        #1 rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (w_enb !== 8'h00) seen++;
        end
        checks++;
        if (seen !== 0 || fill !== 4'd0) begin
            fails++;
            $display("FAIL rst_no_reissue: %0d cycles with enb, fill=%0d, required 0 0", seen, fill);
        end
        $display("reset_during_issue: batch dropped, enb quiet for 40 cycles");
    endtask

    initial begin
        test_reset();
        test_full_batch();
        test_coalesce_timeout();
        test_flush();
        test_back_to_back();
        test_reset_during_issue();
        checks++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d batches never issued, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
